// File: rtl/ysyx_24120013_idu_stage.sv
// ysyx_24120013_idu_stage: RV32I decode stage with a registered bundle; define IDU_SKID_EN for a second (skid) entry.
module ysyx_24120013_idu_stage #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int PC_WIDTH      = 32,
  parameter int COMMAND_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [PC_WIDTH-1:0]      in_pc,
  output logic [ADDR_WIDTH-1:0]    IDU_raddr1,
  output logic [ADDR_WIDTH-1:0]    IDU_raddr2,
  input  logic [DATA_WIDTH-1:0]    rdata1,
  input  logic [DATA_WIDTH-1:0]    rdata2,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    IDU_src1,
  output logic [DATA_WIDTH-1:0]    IDU_src2,
  output logic [ADDR_WIDTH-1:0]    IDU_des,
  output logic [DATA_WIDTH-1:0]    IDU_imm,
  output logic [COMMAND_WIDTH-1:0] IDU_command,
  output logic [2:0]               IDU_funct3,
  output logic                     IDU_funct7b5,
  output logic [PC_WIDTH-1:0]      IDU_pc,
  output logic                     IDU_illegal
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0]    src1;
    logic [DATA_WIDTH-1:0]    src2;
    logic [DATA_WIDTH-1:0]    imm;
    logic [ADDR_WIDTH-1:0]    des;
    logic [COMMAND_WIDTH-1:0] command;
    logic [2:0]               funct3;
    logic                     funct7b5;
    logic [PC_WIDTH-1:0]      pc;
    logic                     illegal;
  } bundle_t;
  logic [3:0] cmd;
  logic signed [31:0] imm32;
  bundle_t dec, out_q;
  logic out_valid_q, in_fire;
  assign IDU_raddr1 = ADDR_WIDTH'(in_inst[19:15]);
  assign IDU_raddr2 = ADDR_WIDTH'(in_inst[24:20]);
  assign in_fire = in_valid && in_ready;
  always_comb begin
    cmd = 4'd0;
    imm32 = '0;
    case (in_inst[6:0])
      7'b0010011: begin cmd = 4'd1;  imm32 = {{20{in_inst[31]}}, in_inst[31:20]}; end
      7'b0110011: cmd = 4'd2;
      7'b0000011: begin cmd = 4'd3;  imm32 = {{20{in_inst[31]}}, in_inst[31:20]}; end
      7'b0100011: begin cmd = 4'd4;  imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]}; end
      7'b1100011: begin cmd = 4'd5;  imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}; end
      7'b0110111: begin cmd = 4'd6;  imm32 = {in_inst[31:12], 12'b0}; end
      7'b0010111: begin cmd = 4'd7;  imm32 = {in_inst[31:12], 12'b0}; end
      7'b1101111: begin cmd = 4'd8;  imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}; end
      7'b1100111: begin cmd = 4'd9;  imm32 = {{20{in_inst[31]}}, in_inst[31:20]}; end
      7'b1110011: begin cmd = 4'd10; imm32 = {{20{in_inst[31]}}, in_inst[31:20]}; end
      7'b0001111: cmd = 4'd11;
      default: cmd = 4'd0;
    endcase
  end
  // imm32 is signed, so the width cast sign-extends when DATA_WIDTH > 32
  assign dec = '{src1: rdata1, src2: rdata2, imm: DATA_WIDTH'(imm32), des: ADDR_WIDTH'(in_inst[11:7]),
                 command: COMMAND_WIDTH'(cmd), funct3: in_inst[14:12], funct7b5: in_inst[30],
                 pc: in_pc, illegal: cmd == 4'd0};
`ifdef IDU_SKID_EN
  bundle_t skid_q;
  logic skid_valid_q;
  assign in_ready = !skid_valid_q && !flush;
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_q <= '0;
      skid_valid_q <= 1'b0;
      skid_q <= '0;
    end else begin
      if (skid_valid_q && out_ready && !flush) out_q <= skid_q;
      else if (in_fire && (!out_valid_q || out_ready)) out_q <= dec;
      if (in_fire && out_valid_q && !out_ready) skid_q <= dec;
      out_valid_q <= !flush && (skid_valid_q || in_fire || (out_valid_q && !out_ready));
      skid_valid_q <= !flush && (skid_valid_q ? !out_ready : (in_fire && out_valid_q && !out_ready));
    end
  end
`else
  assign in_ready = !flush && (!out_valid_q || out_ready);
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_q <= '0;
    end else begin
      if (in_fire) out_q <= dec;
      out_valid_q <= !flush && (in_fire || (out_valid_q && !out_ready));
    end
  end
`endif
  assign out_valid    = out_valid_q;
  assign IDU_src1     = out_q.src1;
  assign IDU_src2     = out_q.src2;
  assign IDU_des      = out_q.des;
  assign IDU_imm      = out_q.imm;
  assign IDU_command  = out_q.command;
  assign IDU_funct3   = out_q.funct3;
  assign IDU_funct7b5 = out_q.funct7b5;
  assign IDU_pc       = out_q.pc;
  assign IDU_illegal  = out_q.illegal;
endmodule

// File: tb/tb_ysyx_24120013_idu_stage.sv
// tb_ysyx_24120013_idu_stage: directed bench for the decode stage (both IDU_SKID_EN builds).
module tb_ysyx_24120013_idu_stage;
  logic clk = 0, rst = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] in_inst = 0, in_pc = 0, rdata1, rdata2;
  logic in_ready, out_valid, IDU_funct7b5, IDU_illegal;
  logic [4:0] IDU_raddr1, IDU_raddr2, IDU_des;
  logic [31:0] IDU_src1, IDU_src2, IDU_imm, IDU_pc;
  logic [3:0] IDU_command;
  logic [2:0] IDU_funct3;
  int checks = 0, fails = 0;

  ysyx_24120013_idu_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .IDU_raddr1(IDU_raddr1), .IDU_raddr2(IDU_raddr2), .rdata1(rdata1), .rdata2(rdata2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .IDU_src1(IDU_src1), .IDU_src2(IDU_src2),
    .IDU_des(IDU_des), .IDU_imm(IDU_imm), .IDU_command(IDU_command), .IDU_funct3(IDU_funct3),
    .IDU_funct7b5(IDU_funct7b5), .IDU_pc(IDU_pc), .IDU_illegal(IDU_illegal)
  );

  always #5 clk = ~clk;
  // regfile stand-in: data identifies which register was read
  assign rdata1 = 32'hA000_0000 | {27'd0, IDU_raddr1};
  assign rdata2 = 32'hB000_0000 | {27'd0, IDU_raddr2};

  localparam logic [31:0] INSTS [12] = '{32'hFFF10093, 32'h00532423, 32'hFE000EE3, 32'h123451B7,
    32'h0000007F, 32'h00100073, 32'h001000EF, 32'hFFFFF297, 32'h00008067, 32'hFFC1A103,
    32'h402081B3, 32'h0FF0000F};
  localparam logic [31:0] IMMS [12] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC, 32'h12345000,
    32'h0, 32'h00000001, 32'h00000800, 32'hFFFFF000, 32'h0, 32'hFFFFFFFC, 32'h0, 32'h0};
  localparam logic [3:0] CMDS [12] = '{4'd1, 4'd4, 4'd5, 4'd6, 4'd0, 4'd10, 4'd8, 4'd7, 4'd9, 4'd3, 4'd2, 4'd11};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 0;
    step;
    step;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (IDU_imm !== 32'h0) begin fails++; $display("FAIL reset_imm got %h exp 0", IDU_imm); end
    checks++; if (IDU_pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp 0", IDU_pc); end
    checks++; if (IDU_src1 !== 32'h0) begin fails++; $display("FAIL reset_src1 got %h exp 0", IDU_src1); end
    checks++; if (IDU_command !== 4'h0 || IDU_illegal !== 1'b0) begin fails++; $display("FAIL reset_cmd got %h/%b exp 0/0", IDU_command, IDU_illegal); end
    rst = 1;
    step;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_decode;
    logic [31:0] w, pc;
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      w = INSTS[i];
      pc = 32'h8000_0000 + 32'(i * 4);
      in_valid = 1; in_inst = w; in_pc = pc;
      #1;
      checks++; if (IDU_raddr1 !== w[19:15] || IDU_raddr2 !== w[24:20]) begin fails++; $display("FAIL raddr[%0d] got %0d/%0d exp %0d/%0d", i, IDU_raddr1, IDU_raddr2, w[19:15], w[24:20]); end
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL dec_in_ready[%0d] got %b exp 1", i, in_ready); end
      step;
      in_valid = 0;
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL dec_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (IDU_imm !== IMMS[i]) begin fails++; $display("FAIL imm[%0d] got %h exp %h", i, IDU_imm, IMMS[i]); end
      checks++; if (IDU_command !== CMDS[i]) begin fails++; $display("FAIL cmd[%0d] got %0d exp %0d", i, IDU_command, CMDS[i]); end
      checks++; if (IDU_illegal !== (CMDS[i] == 4'd0)) begin fails++; $display("FAIL illegal[%0d] got %b exp %b", i, IDU_illegal, CMDS[i] == 4'd0); end
      checks++; if (IDU_des !== w[11:7] || IDU_funct3 !== w[14:12] || IDU_funct7b5 !== w[30]) begin fails++; $display("FAIL fields[%0d] got %0d/%0d/%b", i, IDU_des, IDU_funct3, IDU_funct7b5); end
      checks++; if (IDU_src1 !== (32'hA000_0000 | {27'd0, w[19:15]}) || IDU_src2 !== (32'hB000_0000 | {27'd0, w[24:20]})) begin fails++; $display("FAIL src[%0d] got %h/%h", i, IDU_src1, IDU_src2); end
      checks++; if (IDU_pc !== pc) begin fails++; $display("FAIL pc[%0d] got %h exp %h", i, IDU_pc, pc); end
    end
    step;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dec_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1;
    in_valid = 1;
    in_inst = 32'hFFF10093;
    for (int i = 0; i < 4; i++) begin
      in_pc = 32'h1000 + 32'(i * 4);
      #1;
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready); end
      step;
      checks++; if (out_valid !== 1'b1 || IDU_pc !== 32'h1000 + 32'(i * 4)) begin fails++; $display("FAIL b2b_out[%0d] got %b/%h exp 1/%h", i, out_valid, IDU_pc, 32'h1000 + 32'(i * 4)); end
    end
    in_valid = 0;
    step;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure;
    logic [31:0] pcs [5] = '{32'h2000, 32'h2010, 32'h2020, 32'h2030, 32'h2040};
    int idx = 0, oidx = 0, stall_acc = 0;
    logic fin;
`ifdef IDU_SKID_EN
    int exp_acc = 2;
`else
    int exp_acc = 1;
`endif
    in_inst = 32'h00532423;
    for (int cyc = 0; cyc < 40 && oidx < 5; cyc++) begin
      in_valid = idx < 5;
      in_pc = pcs[idx < 5 ? idx : 4];
      out_ready = cyc >= 3;
      #1;
      fin = in_valid && in_ready;
      if (cyc < 3 && fin) stall_acc++;
      if (cyc == 2) begin
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_stall got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || IDU_pc !== pcs[0]) begin fails++; $display("FAIL bp_hold got %b/%h exp 1/%h", out_valid, IDU_pc, pcs[0]); end
      end
      if (out_valid && out_ready) begin
        checks++; if (IDU_pc !== pcs[oidx]) begin fails++; $display("FAIL bp_order[%0d] got %h exp %h", oidx, IDU_pc, pcs[oidx]); end
        oidx++;
      end
      step;
      if (fin) idx++;
    end
    in_valid = 0;
    checks++; if (stall_acc !== exp_acc) begin fails++; $display("FAIL bp_accepted got %0d exp %0d", stall_acc, exp_acc); end
    checks++; if (oidx !== 5) begin fails++; $display("FAIL bp_count got %0d exp 5", oidx); end
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_dup got %b exp 0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 0;
    in_valid = 1;
    in_inst = 32'hFFF10093;
    in_pc = 32'h100;
    step;
`ifdef IDU_SKID_EN
    in_pc = 32'h104;
    step;
`endif
    in_pc = 32'h108;
    flush = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_ready_during got %b exp 0", in_ready); end
    step;
    flush = 0;
    in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready_after got %b exp 1", in_ready); end
    checks++; if (IDU_pc !== 32'h100) begin fails++; $display("FAIL flush_hold got %h exp 100", IDU_pc); end
    step;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_accept got %b exp 0", out_valid); end
  endtask

  task automatic test_mid_reset;
    out_ready = 0;
    in_valid = 1;
    in_inst = 32'h123451B7;
    in_pc = 32'h200;
    step;
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mr_stalled got %b exp 1", out_valid); end
    rst = 0;
    step;
    rst = 1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mr_valid got %b exp 0", out_valid); end
    checks++; if (IDU_pc !== 32'h0 || IDU_imm !== 32'h0 || IDU_src1 !== 32'h0 || IDU_command !== 4'h0) begin fails++; $display("FAIL mr_data got %h/%h/%h/%h exp 0", IDU_pc, IDU_imm, IDU_src1, IDU_command); end
    out_ready = 1;
    in_valid = 1;
    in_inst = 32'hFFF10093;
    in_pc = 32'h300;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mr_ready got %b exp 1", in_ready); end
    step;
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || IDU_pc !== 32'h300) begin fails++; $display("FAIL mr_fresh got %b/%h exp 1/300", out_valid, IDU_pc); end
    checks++; if (IDU_imm !== 32'hFFFFFFFF || IDU_command !== 4'd1 || IDU_des !== 5'd1 || IDU_src1 !== 32'hA000_0002) begin fails++; $display("FAIL mr_decode got %h/%0d/%0d/%h", IDU_imm, IDU_command, IDU_des, IDU_src1); end
    step;
  endtask

  initial begin
    test_reset;
    test_decode;
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_24120013_idu_stage.md
# ysyx_24120013_idu_stage

Pipelined RV32I instruction decode stage between the IFU and EXU of the NPC core. Accepts one fetched instruction and PC per cycle over a valid/ready handshake. Decodes all RV32I immediate formats and instruction classes, captures register-file read data, and presents a registered decode bundle downstream with backpressure and flush support. An optional skid buffer registers the upstream ready path.

## Interface
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, register data and immediate width; must be ≥ 32, immediates sign-extended to it
- PC_WIDTH, 32, program counter width
- COMMAND_WIDTH, 4, instruction class code width; must be ≥ 4
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-low
- in_valid  input  1  IFU offers in_inst/in_pc
- in_ready  output  1  stage can accept this cycle
- in_inst  input  32  instruction word
- in_pc  input  PC_WIDTH  PC of in_inst
- IDU_raddr1  output  ADDR_WIDTH  in_inst[19:15], combinational
- IDU_raddr2  output  ADDR_WIDTH  in_inst[24:20], combinational
- rdata1  input  DATA_WIDTH  regfile data for IDU_raddr1, same cycle
- rdata2  input  DATA_WIDTH  regfile data for IDU_raddr2, same cycle
- flush  input  1  discard every buffered entry (redirect)
- out_valid  output  1  decode bundle valid
- out_ready  input  1  EXU accepts bundle
- IDU_src1, IDU_src2  output  DATA_WIDTH  captured rdata1/rdata2
- IDU_des  output  ADDR_WIDTH  inst[11:7]
- IDU_imm  output  DATA_WIDTH  decoded immediate
- IDU_command  output  COMMAND_WIDTH  instruction class
- IDU_funct3  output  3  inst[14:12]
- IDU_funct7b5  output  1  inst[30]
- IDU_pc  output  PC_WIDTH  captured in_pc
- IDU_illegal  output  1  unrecognised opcode

## Operation
- Transfer in: in_valid && in_ready at edge. Transfer out: out_valid && out_ready at edge.
- Immediate by opcode: I (0010011, 0000011, 1100111, 1110011) {sext inst[31:20]}; S (0100011) {inst[31:25],inst[11:7]}; B (1100011) {inst[31],inst[7],inst[30:25],inst[11:8],0}; U (0110111, 0010111) {inst[31:12],12'b0}; J (1101111) {inst[31],inst[19:12],inst[20],inst[30:21],0}; all sign-extended to DATA_WIDTH; others 0.
- IDU_command: 0 illegal, 1 OP-IMM, 2 OP, 3 LOAD, 4 STORE, 5 BRANCH, 6 LUI, 7 AUIPC, 8 JAL, 9 JALR, 10 SYSTEM, 11 MISC-MEM. Codes 12..max reserved, never emitted.
- Unlisted opcode: IDU_command=0, IDU_illegal=1, IDU_imm=0, passed downstream as a normal bundle.
- Output register: loaded on transfer in when empty or draining the same cycle.
- flush: clears out_valid and skid state next edge; in_ready forced 0 that cycle, so no instruction accepted while flush=1. Flush overrides a simultaneous transfer in; a simultaneous transfer out still completes.
- Data outputs hold their value while out_valid=0; only valid bits are cleared by flush.

## Timing
- Reset: out_valid=0, every data output 0, skid empty. in_ready=1 from the first cycle after reset release, provided flush=0.
- Latency: transfer in at edge N gives out_valid=1 after edge N, so the bundle is visible in cycle N+1.
- Throughput: 1 instruction/cycle with out_ready held high.
- Stall: while out_valid && !out_ready, all bundle outputs stable.
- Order: strict FIFO; no loss, no duplication under any pattern of in_valid, out_ready.
- Reset mid-operation discards every entry, regardless of flush.

## Configuration
- IDU_SKID_EN defined: adds a 2nd entry (skid). in_ready is a flop, equal to "skid empty". One transfer in is absorbed during the first stall cycle. The skid entry moves to the output register on the next transfer out.
- IDU_SKID_EN undefined: single entry. in_ready = !flush && (!out_valid || out_ready), combinational. Same latency and throughput.

## Test plan
- addi x1,x2,-1 (0xFFF10093) -> IDU_raddr1=2 same cycle; next cycle out_valid=1, IDU_imm=0xFFFFFFFF, IDU_command=1, IDU_des=1, IDU_src1=rdata1 at accept.
- sw x5,8(x6) (0x00532423) -> imm=0x8, command=4, raddr2=5. beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, command=5. lui x3,0x12345 (0x123451B7) -> imm=0x12345000, command=6.
- 0x0000007F -> command=0, illegal=1, imm=0. ebreak (0x00100073) -> command=10, illegal=0.
- Backpressure: in_valid=1 continuously with 5 distinct PCs, out_ready=0 for 3 cycles then 1. SKID_EN: exactly 2 accepted before in_ready=0. No SKID: 1 accepted. All 5 emerge in order, no duplicates.
- flush with output and skid full -> next cycle out_valid=0, in_ready=1; the in_valid offered during flush is not accepted.
- rst=0 asserted for one cycle with a bundle stalled -> out_valid=0 and outputs 0 next cycle; a fresh addi then decodes correctly.
